// File: rtl/snd_pkg.sv
// Shared types and constants for the stochastic-number decoder.
package snd_pkg;

    // Conversion FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAcc  = 2'd2,
        StDone = 2'd3
    } snd_state_e;

    // Default stream window and start delay.
    localparam int unsigned SND_STREAM_LEN_DEF = 16;
    localparam int unsigned SND_START_DLY_DEF  = 0;
    localparam int unsigned SND_OUT_W_DEF      = 4;

    // Ones counter must hold every value from 0 to len inclusive.
    function automatic int unsigned ones_cnt_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/snd_ones_counter.sv
// Ones counter for the stochastic decoder, plus the output clamp.
// Build option: SND_SATURATE_EN clamps the output at 2^OUT_W-1; otherwise
// the output is the count modulo 2^OUT_W.
module snd_ones_counter
    import snd_pkg::*;
#(
    parameter int unsigned CNT_W = ones_cnt_width(SND_STREAM_LEN_DEF),
    parameter int unsigned OUT_W = SND_OUT_W_DEF
) (
    input  logic             i_clk_snd,
    input  logic             i_rst_snd,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [OUT_W-1:0] o_x_bn
);

    localparam logic [31:0] MaxOut = (32'd1 << OUT_W) - 32'd1;

    logic [CNT_W-1:0] ones_q;
    logic [31:0]      ones_ext;

    // Count sampled ones; clear takes priority over counting.
    always_ff @(posedge i_clk_snd) begin
        if (i_rst_snd) begin
            ones_q <= '0;
        end else if (i_clr) begin
            ones_q <= '0;
        end else if (i_en && i_bit) begin
            ones_q <= ones_q + 1'b1;
        end
    end

    // Map the count onto the output width.
    always_comb begin
        ones_ext = 32'(ones_q);
`ifdef SND_SATURATE_EN
        if (ones_ext > MaxOut) begin
            o_x_bn = OUT_W'(MaxOut);
        end else begin
            o_x_bn = OUT_W'(ones_ext);
        end
`else
        o_x_bn = OUT_W'(ones_ext);
`endif
    end

endmodule

// File: rtl/sn_decoder.sv
// Stochastic-to-binary converter: counts ones over a fixed window of stream
// slots and hands the result to a consumer with a valid/ready handshake.
// Build option: SND_SATURATE_EN selects a saturating output clamp (see
// snd_ones_counter); FSM and timing are the same in both builds.
module sn_decoder
    import snd_pkg::*;
#(
    parameter int unsigned STREAM_LEN = SND_STREAM_LEN_DEF,
    parameter int unsigned START_DLY  = SND_START_DLY_DEF,
    parameter int unsigned OUT_W      = SND_OUT_W_DEF
) (
    input  logic             i_clk_snd,
    input  logic             i_rst_snd,
    input  logic             i_start_snd,
    input  logic             i_stop_snd,
    input  logic             i_sn_bit,
    input  logic             i_ready_snd,
    output logic [OUT_W-1:0] o_x_bn,
    output logic             o_valid_snd,
    output logic             o_busy_snd,
    output logic             o_trunc_snd
);

    localparam int unsigned CNT_W  = ones_cnt_width(STREAM_LEN);
    localparam int unsigned SLOT_W = $clog2(STREAM_LEN);
    localparam int unsigned DLY_W  = 4;

    localparam logic [SLOT_W-1:0] SlotLast = SLOT_W'(STREAM_LEN - 1);
    localparam logic [DLY_W-1:0]  DlyLast  = DLY_W'((START_DLY > 0) ? START_DLY - 1 : 0);

    snd_state_e        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              trunc_q, trunc_d;
    logic              cnt_clr;
    logic              cnt_en;

    // State, slot counter, delay counter and truncation flag.
    always_ff @(posedge i_clk_snd) begin
        if (i_rst_snd) begin
            state_q <= StIdle;
            slot_q  <= '0;
            dly_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            dly_q   <= dly_d;
            trunc_q <= trunc_d;
        end
    end

    // Next-state logic and ones-counter control.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        dly_d   = dly_q;
        trunc_d = trunc_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A stop arriving with the start is simply ignored here.
                if (i_start_snd) begin
                    cnt_clr = 1'b1;
                    slot_d  = '0;
                    dly_d   = '0;
                    trunc_d = 1'b0;
                    state_d = (START_DLY > 0) ? StWait : StAcc;
                end
            end
            StWait: begin
                if (i_stop_snd) begin
                    trunc_d = 1'b1;
                    state_d = StDone;
                end else if (dly_q == DlyLast) begin
                    state_d = StAcc;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            StAcc: begin
                // The bit present in the stop cycle is not sampled.
                if (i_stop_snd) begin
                    trunc_d = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_en = 1'b1;
                    slot_d = slot_q + 1'b1;
                    if (slot_q == SlotLast) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Start requests here are dropped; no auto-restart.
                if (i_ready_snd) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs decoded from registered state.
    always_comb begin
        o_valid_snd = (state_q == StDone);
        o_busy_snd  = (state_q == StWait) || (state_q == StAcc);
        o_trunc_snd = trunc_q && (state_q == StDone);
    end

    snd_ones_counter #(
        .CNT_W (CNT_W),
        .OUT_W (OUT_W)
    ) u_ones_counter (
        .i_clk_snd (i_clk_snd),
        .i_rst_snd (i_rst_snd),
        .i_clr     (cnt_clr),
        .i_en      (cnt_en),
        .i_bit     (i_sn_bit),
        .o_x_bn    (o_x_bn)
    );

endmodule
